// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory responder.
//   state_e        : responder FSM states
//   F3*            : RV32I funct3 access-size / sign-mode encodings
//   Default*       : default parameter values for data_mem_responder
package data_mem_pkg;

  localparam int unsigned DefaultAddrW      = 10;
  localparam int unsigned DefaultWaitCycles = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Loads
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  // Stores
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian data memory.
//   we_i       : 1 = store, 0 = load
//   mode_i     : funct3 size / sign mode
//   addr_lo_i  : byte offset within the word
//   wdata_i    : raw store data (low bits used for SB/SH)
//   rword_i    : word currently held at the addressed word location
//   be_o       : per-byte write enables (all zero on error or load)
//   wlanes_o   : store data replicated onto the byte lanes
//   rdata_o    : extended load result (zero on store or error)
//   err_o      : misaligned access or illegal mode
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  mode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic        legal;
  logic        misalign;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    if (we_i) begin
      legal = (mode_i == F3Sb) || (mode_i == F3Sh) || (mode_i == F3Sw);
    end else begin
      legal = (mode_i == F3Lb) || (mode_i == F3Lh) || (mode_i == F3Lw) ||
              (mode_i == F3Lbu) || (mode_i == F3Lhu);
    end
    misalign = ((mode_i[1:0] == 2'b01) && addr_lo_i[0]) ||
               ((mode_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    err_o    = !legal || misalign;

    case (addr_lo_i)
      2'd0:    rbyte = rword_i[7:0];
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      default: rbyte = rword_i[31:24];
    endcase
    rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    be_o     = 4'b0000;
    wlanes_o = 32'h0;
    rdata_o  = 32'h0;
    if (!err_o) begin
      if (we_i) begin
        case (mode_i[1:0])
          2'b00: begin
            be_o     = 4'b0001 << addr_lo_i;
            wlanes_o = {4{wdata_i[7:0]}};
          end
          2'b01: begin
            be_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wlanes_o = {2{wdata_i[15:0]}};
          end
          default: begin
            be_o     = 4'b1111;
            wlanes_o = wdata_i;
          end
        endcase
      end else begin
        case (mode_i)
          F3Lb:    rdata_o = {{24{rbyte[7]}}, rbyte};
          F3Lh:    rdata_o = {{16{rhalf[15]}}, rhalf};
          F3Lbu:   rdata_o = {24'h0, rbyte};
          F3Lhu:   rdata_o = {16'h0, rhalf};
          default: rdata_o = rword_i;
        endcase
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a byte-addressed RAM with a
// fixed number of wait states.
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake (ready only when idle)
//   req_we/req_mode/req_addr   : store flag, funct3 mode, byte address
//   req_wdata                  : store data
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata/rsp_err          : extended load data, error flag
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned Words = 2 ** (ADDR_W - 2);

  // Word-organised so an aligned access never straddles a row.
  logic [31:0] mem_q [Words];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        access;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] al_rdata;
  logic        al_err;

  assign access = (state_q == StWait) && (cnt_q == 4'd0);
  assign rword  = mem_q[addr_q[ADDR_W-1:2]];

  mem_lane_align u_align (
    .we_i     (we_q),
    .mode_i   (mode_q),
    .addr_lo_i(addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rword_i  (rword),
    .be_o     (be),
    .wlanes_o (wlanes),
    .rdata_o  (al_rdata),
    .err_o    (al_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          mode_d  = req_mode;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = al_rdata;
          err_d   = al_err;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      mode_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (access) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[ADDR_W-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus tasks push expected
// responses, monitors pop and compare on each response handshake.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [2:0]  req_mode = 3'b000;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
  logic [2:0]  req_mode0 = 3'b000;
  logic [9:0]  req_addr0 = '0;
  logic [31:0] req_wdata0 = '0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_q0[$];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_mode(req_mode0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitors: compare on every response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if (rsp_rdata !== e[32:1] || rsp_err !== e[0]) begin
          errors++;
          $display("FAIL rsp: got rdata %h err %b expected rdata %h err %b",
                   rsp_rdata, rsp_err, e[32:1], e[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid0 && rsp_ready0) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp0: got rdata %h err %b expected none", rsp_rdata0, rsp_err0);
      end else begin
        logic [32:0] e;
        e = exp_q0.pop_front();
        if (rsp_rdata0 !== e[32:1] || rsp_err0 !== e[0]) begin
          errors++;
          $display("FAIL rsp0: got rdata %h err %b expected rdata %h err %b",
                   rsp_rdata0, rsp_err0, e[32:1], e[0]);
        end
      end
    end
  end

  // Present one request, scramble inputs after acceptance, wait for rsp_valid
  // and check the latency. push=0 issues without expecting a response.
  task automatic issue(input logic we, input logic [2:0] mode, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee,
                       input bit push = 1'b1);
    int n;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
    if (push) exp_q.push_back({er, ee});
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_mode = 3'b111; req_addr = ~addr; req_wdata = ~wdata;
    if (!push) return;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) break;
    end
    check("latency", 32'(n), 32'd3);
  endtask

  task automatic complete();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  task automatic xfer(input logic we, input logic [2:0] mode, input logic [9:0] addr,
                      input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    issue(we, mode, addr, wdata, er, ee);
    complete();
  endtask

  task automatic xfer0(input logic we, input logic [2:0] mode, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    int n;
    @(negedge clk);
    check("req_ready0_idle", 32'(req_ready0), 32'd1);
    req_valid0 = 1'b1; req_we0 = we; req_mode0 = mode; req_addr0 = addr; req_wdata0 = wdata;
    exp_q0.push_back({er, ee});
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_addr0 = ~addr; req_wdata0 = ~wdata;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid0) break;
    end
    check("latency0", 32'(n), 32'd1);
    @(posedge clk); #1;
    check("rsp0_done", 32'(rsp_valid0), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Store word, read back and sub-word loads
    xfer(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer(1'b0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    xfer(1'b0, 3'b000, 10'h013, 32'h0, 32'hFFFFFFDE, 1'b0);
    xfer(1'b0, 3'b100, 10'h013, 32'h0, 32'h000000DE, 1'b0);
    xfer(1'b0, 3'b001, 10'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
    xfer(1'b0, 3'b101, 10'h010, 32'h0, 32'h0000BEEF, 1'b0);
    xfer(1'b0, 3'b000, 10'h010, 32'h0, 32'hFFFFFFEF, 1'b0);

    // Byte and half stores use only the low data bits
    xfer(1'b1, 3'b000, 10'h011, 32'hFFFFFF55, 32'h0, 1'b0);
    xfer(1'b0, 3'b010, 10'h010, 32'h0, 32'hDEAD55EF, 1'b0);
    xfer(1'b0, 3'b000, 10'h011, 32'h0, 32'h00000055, 1'b0);
    xfer(1'b1, 3'b001, 10'h012, 32'hABCD1234, 32'h0, 1'b0);
    xfer(1'b0, 3'b010, 10'h010, 32'h0, 32'h123455EF, 1'b0);

    // Misaligned and illegal modes: error, no write
    xfer(1'b0, 3'b010, 10'h012, 32'h0, 32'h0, 1'b1);
    xfer(1'b1, 3'b001, 10'h011, 32'h00000000, 32'h0, 1'b1);
    xfer(1'b0, 3'b011, 10'h010, 32'h0, 32'h0, 1'b1);
    xfer(1'b1, 3'b100, 10'h010, 32'h00000000, 32'h0, 1'b1);
    xfer(1'b1, 3'b010, 10'h013, 32'h00000000, 32'h0, 1'b1);
    xfer(1'b0, 3'b010, 10'h010, 32'h0, 32'h123455EF, 1'b0);

    // Top-of-memory word and wrap-around of the low word
    xfer(1'b1, 3'b010, 10'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
    xfer(1'b1, 3'b010, 10'h000, 32'h01020304, 32'h0, 1'b0);
    xfer(1'b0, 3'b001, 10'h3FE, 32'h0, 32'hFFFFCAFE, 1'b0);
    xfer(1'b0, 3'b101, 10'h000, 32'h0, 32'h00000304, 1'b0);

    // Back-pressure: response held, no acceptance in the window
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 10'h010, 32'h0, 32'h123455EF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, 32'h123455EF);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      if (i == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b010;
        req_addr = 10'h010; req_wdata = 32'h0BADF00D;
      end else begin
        req_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    complete();
    repeat (3) @(posedge clk);
    xfer(1'b0, 3'b010, 10'h010, 32'h0, 32'h123455EF, 1'b0);

    // Reset during wait states: store must be dropped, no response
    xfer(1'b1, 3'b010, 10'h020, 32'h12345678, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 10'h020, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    xfer(1'b0, 3'b010, 10'h020, 32'h0, 32'h12345678, 1'b0);

    // Zero wait states
    xfer0(1'b1, 3'b010, 10'h040, 32'h89ABCDEF, 32'h0, 1'b0);
    xfer0(1'b0, 3'b000, 10'h041, 32'h0, 32'hFFFFFFCD, 1'b0);
    xfer0(1'b0, 3'b001, 10'h041, 32'h0, 32'h0, 1'b1);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_q0.size() != 0) begin
      errors++;
      $display("FAIL pending_rsp: got %0d/%0d outstanding expected 0/0",
               exp_q.size(), exp_q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
